mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit in the Execute stage. It consumes the same operand pair the ALU does: operandA from ALU input mux 1 and operandB from the `aluInputSelectMux2` output (`input2Alu`). It produces a 32-bit result with a fixed 34-cycle latency. The hazard unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- none; width is fixed at 32 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE or DONE.
- flush  input  1  synchronous abort of any operation in progress.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  input  32  rs1 value (multiplicand / dividend).
- operandB  input  32  ALU input 2 value (multiplier / divisor).
- busy  output  1  high in PREP and CALC.
- done  output  1  single-cycle pulse; high only in DONE.
- result  output  32  registered result; holds until the next completion.

## Operation
- States: IDLE, PREP, CALC, DONE.
- IDLE/DONE with start=1 and flush=0:
  - Capture funct3, operandA and operandB; go to PREP.
  - Later changes on the operand inputs do not affect the operation.
- DONE with start=0: go to IDLE.
- PREP, one cycle:
  - Compute operand signs per funct3. MULH, DIV and REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. The rest are unsigned.
  - Load magnitudes.
  - Clear the iteration counter (6 bits).
  - Flag div-by-zero (B==0) and signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF).
- CALC, exactly 32 cycles, one iteration per cycle:
  - Multiply: shift-add on a 64-bit product of magnitudes.
  - Divide: restoring division; 32-bit quotient and remainder of magnitudes.
  - Go to DONE when counter==31.
- Transition edge CALC→DONE, result register loaded:
  - MUL: low 32 bits of the signed-corrected 64-bit product.
  - MULH, MULHSU, MULHU: high 32 bits, negated as 64-bit if the product sign is negative.
  - DIV/DIVU: quotient, negated if operand signs differ (signed op).
  - REM/REMU: remainder, taking the sign of the dividend.
  - Div-by-zero: quotient=0xFFFFFFFF; remainder=operandA unchanged.
  - Overflow: quotient=0x80000000; remainder=0.
- There is no early termination. Special cases still take the full latency.
- flush=1 in any state:
  - Next state is IDLE; done=0.
  - result is unchanged.
  - flush has priority over start in the same cycle.
- start while busy=1 is ignored.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0x00000000, counter=0.
- Reset has priority over flush and start. Reset mid-operation returns to IDLE next edge with no done.
- Latency, with start sampled at edge E0:
  - PREP in cycle after E0.
  - CALC in cycles after E1..E32.
  - DONE in cycle after E33; done=1 and result valid there.
- busy is high in cycles after E0..E32 and low in the DONE cycle.
- Back-to-back operation: start=1 in the DONE cycle begins the next operation at that edge. Throughput is one op per 34 cycles.
- done is never high for two consecutive cycles.
- Arithmetic:
  - Internal product is 64 bits; remainder accumulator is 33 bits.
  - Negation is two's complement.
  - Negating 0x80000000 magnitude yields 0x80000000; no saturation.

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3) → result 0xFFFFFFEB, done exactly 34 cycles after start, busy high for 33 cycles.
- MULH A=B=0x80000000 → 0x40000000; MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; REMU A=7, B=2 → 1.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - All at 34-cycle latency.
- Flush at cycle 10 of a DIV → busy=0 next cycle, no done pulse, result keeps the previous value. Then start MUL 3×4 with flush=1 in the same cycle → ignored. Then restart with flush=0 → 12.
- Reset asserted at cycle 20 of a MUL → all outputs return to reset values next cycle. Back-to-back start in the DONE cycle → second done exactly 34 cycles after the first.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Each operation takes a fixed 34 cycles: one capture edge, one PREP cycle,
// 32 CALC iterations, and a one-cycle DONE pulse with a registered result.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  funct3,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {StIdle, StPrep, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic        div_zero_q, div_zero_d;
    logic        ovf_q, ovf_d;
    logic [31:0] mag_b_q, mag_b_d;
    // Multiply: high half of the running product. Divide: partial remainder.
    logic [32:0] acc_q, acc_d;
    // Multiply: low product half / remaining multiplier. Divide: dividend/quotient.
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic        signed_a, signed_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] mul_acc_nx;
    logic [31:0] mul_lo_nx;
    logic [33:0] diff;
    logic [32:0] div_acc_nx;
    logic [31:0] div_lo_nx;
    logic [63:0] prod, prod_s;
    logic [31:0] quo, rem;
    logic [31:0] final_res;

    // Operand signedness and magnitudes from the captured operation.
    always_comb begin
        signed_a = (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                   (funct3_q == 3'b100) || (funct3_q == 3'b110);
        signed_b = (funct3_q == 3'b001) || (funct3_q == 3'b100) || (funct3_q == 3'b110);
        abs_a    = (signed_a && opa_q[31]) ? -opa_q : opa_q;
        abs_b    = (signed_b && opb_q[31]) ? -opb_q : opb_q;
    end

    // One shift-add / restoring-divide iteration, plus the final sign correction.
    always_comb begin
        // acc_q[32] is always zero between iterations, so the 33-bit sum cannot overflow.
        mul_sum    = acc_q + (lo_q[0] ? {1'b0, mag_b_q} : 33'd0);
        mul_acc_nx = {1'b0, mul_sum[32:1]};
        mul_lo_nx  = {mul_sum[0], lo_q[31:1]};

        diff       = {acc_q, lo_q[31]} - {2'b00, mag_b_q};
        div_acc_nx = diff[33] ? {acc_q[31:0], lo_q[31]} : diff[32:0];
        div_lo_nx  = {lo_q[30:0], ~diff[33]};

        prod   = {mul_acc_nx[31:0], mul_lo_nx};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo    = div_lo_nx;
        rem    = div_acc_nx[31:0];

        final_res = '0;
        unique case (funct3_q)
            3'b000: final_res = prod_s[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[63:32];
            3'b100, 3'b101: begin
                if (div_zero_q)             final_res = 32'hFFFF_FFFF;
                else if (ovf_q)             final_res = 32'h8000_0000;
                else if (neg_a_q ^ neg_b_q) final_res = -quo;
                else                        final_res = quo;
            end
            default: begin
                if (div_zero_q)   final_res = opa_q;
                else if (ovf_q)   final_res = 32'h0000_0000;
                else if (neg_a_q) final_res = -rem;
                else              final_res = rem;
            end
        endcase
    end

    // Next-state and datapath updates; flush overrides everything except reset.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        result_d   = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    funct3_d = funct3;
                    opa_d    = operandA;
                    opb_d    = operandB;
                    state_d  = StPrep;
                end else begin
                    state_d  = StIdle;
                end
            end
            StPrep: begin
                neg_a_d    = signed_a && opa_q[31];
                neg_b_d    = signed_b && opb_q[31];
                mag_b_d    = abs_b;
                lo_d       = abs_a;
                acc_d      = '0;
                cnt_d      = '0;
                div_zero_d = (opb_q == 32'h0);
                ovf_d      = ((funct3_q == 3'b100) || (funct3_q == 3'b110)) &&
                             (opa_q == 32'h8000_0000) && (opb_q == 32'hFFFF_FFFF);
                state_d    = StCalc;
            end
            default: begin
                acc_d = funct3_q[2] ? div_acc_nx : mul_acc_nx;
                lo_d  = funct3_q[2] ? div_lo_nx : mul_lo_nx;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    result_d = final_res;
                    state_d  = StDone;
                end
            end
        endcase

        if (flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            funct3_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy   = (state_q == StPrep) || (state_q == StCalc);
        done   = (state_q == StDone);
        result = result_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected results,
// latency/busy checks, special cases, flush, reset and back-to-back issue.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] operandA, operandB;
    logic        busy, done;
    logic [31:0] result;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .funct3   (funct3),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model built on native 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sub, p;
        logic [63:0]        ua, ub, up;
        logic [31:0]        r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sub = {32'h0, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        r   = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * sub; r = p[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Present an operation for the next edge and record its expected result.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3   = f;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        flush    = 1'b0;
        exp_q.push_back(model(f, a, b));
    endtask

    // Count edges from the start edge until done; scrambles operands after capture.
    task automatic wait_done(output int cycles, output logic [31:0] res);
        cycles = 0;
        res    = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start    = 1'b0;
            operandA = $urandom;
            operandB = $urandom;
            if (done) begin
                cycles = k;
                res    = result;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n, output int done_seen);
        done_seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; operandA = '0; operandB = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state busy=%b done=%b result=%h want 0 0 00000000",
                     busy, done, result);
        end
    endtask

    task automatic test_mul_timing;
        int          busy_cnt, done_at;
        logic [31:0] e;
        busy_cnt = 0;
        done_at  = 0;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = k;
        end
        e = exp_q.pop_front();
        last_exp = e;
        vectors++;
        if (busy_cnt !== 33) begin
            miscompares++;
            $display("FAIL mul_busy_cycles got %0d want 33", busy_cnt);
        end
        vectors++;
        if (done_at !== 34) begin
            miscompares++;
            $display("FAIL mul_done_latency got %0d want 34", done_at);
        end
        vectors++;
        if (result !== e || e !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mul_7x-3 got %h want %h", result, e);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || result !== e) begin
            miscompares++;
            $display("FAIL mul_done_pulse done=%b result=%h want 0 %h", done, result, e);
        end
    endtask

    // Table-driven ops: arithmetic cases, special cases and random operands.
    task automatic test_ops;
        logic [2:0]  f_t[14];
        logic [31:0] a_t[14];
        logic [31:0] b_t[14];
        int          cyc;
        logic [31:0] res, e;
        f_t = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6,
                3'd1, 3'd2};
        a_t = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB,
                32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h8000_0000};
        b_t = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFFF};
        for (int i = 0; i < 14 + 8; i++) begin
            if (i < 14) issue(f_t[i], a_t[i], b_t[i]);
            else issue(3'($urandom_range(0, 7)), $urandom, $urandom);
            wait_done(cyc, res);
            e = exp_q.pop_front();
            last_exp = e;
            vectors++;
            if (res !== e) begin
                miscompares++;
                $display("FAIL op%0d f=%0d result got %h want %h", i, funct3, res, e);
            end
            vectors++;
            if (cyc !== 34) begin
                miscompares++;
                $display("FAIL op%0d latency got %0d want 34", i, cyc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush;
        int          dseen, cyc;
        logic [31:0] res, e;
        issue(3'd4, 32'd100, 32'd7);
        void'(exp_q.pop_front());
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_abort busy=%b done=%b want 0 0", busy, done);
        end
        idle_cycles(40, dseen);
        vectors++;
        if (dseen !== 0 || result !== last_exp) begin
            miscompares++;
            $display("FAIL flush_no_done done_cycles=%0d result=%h want 0 %h",
                     dseen, result, last_exp);
        end
        // start together with flush must be ignored.
        funct3 = 3'd0; operandA = 32'd3; operandB = 32'd4; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_over_start busy=%b want 0", busy);
        end
        idle_cycles(40, dseen);
        vectors++;
        if (dseen !== 0 || result !== last_exp) begin
            miscompares++;
            $display("FAIL flush_start_ignored done_cycles=%0d result=%h want 0 %h",
                     dseen, result, last_exp);
        end
        issue(3'd0, 32'd3, 32'd4);
        wait_done(cyc, res);
        e = exp_q.pop_front();
        last_exp = e;
        vectors++;
        if (res !== e || cyc !== 34) begin
            miscompares++;
            $display("FAIL restart_mul result=%h cycles=%0d want %h 34", res, cyc, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int dseen;
        issue(3'd0, 32'h1234, 32'h5678);
        void'(exp_q.pop_front());
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid busy=%b done=%b result=%h want 0 0 00000000",
                     busy, done, result);
        end
        idle_cycles(40, dseen);
        vectors++;
        if (dseen !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done got %0d done cycles want 0", dseen);
        end
        last_exp = 32'h0;
    endtask

    task automatic test_back_to_back;
        int          cyc1, cyc2;
        logic [31:0] r1, r2, e1, e2;
        issue(3'd0, 32'd6, 32'd9);
        wait_done(cyc1, r1);
        // Still in the DONE cycle: issue the next op immediately.
        issue(3'd5, 32'd1000, 32'd7);
        wait_done(cyc2, r2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        vectors++;
        if (r1 !== e1 || cyc1 !== 34) begin
            miscompares++;
            $display("FAIL b2b_first result=%h cycles=%0d want %h 34", r1, cyc1, e1);
        end
        vectors++;
        if (r2 !== e2 || cyc2 !== 34) begin
            miscompares++;
            $display("FAIL b2b_second result=%h cycles=%0d want %h 34", r2, cyc2, e2);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_single_pulse done=%b want 0", done);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_ops();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
